ks_excite_gen: RTL and testbench

//  Karplus-Strong excitation sequencer; sits directly upstream of the delay-line register.
//  On a pluck request it clears the delay line for one cycle, then streams a burst of LFSR

---
 rtl/ks_excite_gen.sv | 114 +++++++++++
 tb/tb_ks_excite_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ks_excite_gen.sv
// ---------------------------------------------------------------------------
// ks_excite_gen : Karplus-Strong excitation sequencer (clear, noise burst, ring)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ks_excite_gen #(
  parameter int          WIDTH     = 16,
  parameter int          LEN_W     = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             a_clk,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic             pluck,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [3:0]       amp_shift,
  output logic [WIDTH-1:0] dnoise,
  output logic             trigger,
  output logic             sclr,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0] c_LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_BURST = 2'd2,
    S_RING  = 2'd3
  } state_t;

  state_t             r_state;
  logic [15:0]        r_lfsr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_count;
  logic [3:0]         r_amp;

  logic [15:0]        w_lfsr_next;
  logic signed [15:0] w_shifted;
  logic [WIDTH-1:0]   w_noise;
  logic [LEN_W-1:0]   w_len_in;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_POLY : 16'h0000);
  assign w_shifted   = $signed(r_lfsr) >>> r_amp;
  // A zero-length request still produces one noise sample.
  assign w_len_in    = (burst_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : burst_len;

  generate
    if (WIDTH > 16) begin : g_wide
      assign w_noise = {{(WIDTH-16){w_shifted[15]}}, w_shifted};
    end else if (WIDTH == 16) begin : g_exact
      assign w_noise = w_shifted;
    end else begin : g_narrow
      assign w_noise = w_shifted[15 -: WIDTH];
    end
  endgenerate

  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_len   <= '0;
      r_count <= '0;
      r_amp   <= '0;
      dnoise  <= '0;
      trigger <= 1'b1;
      sclr    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      sclr <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_RING: begin
          if (pluck) begin
            r_state <= S_CLEAR;
            r_len   <= w_len_in;
            r_amp   <= amp_shift;
            r_count <= '0;
            sclr    <= 1'b1;
            busy    <= 1'b1;
            trigger <= 1'b1;
            dnoise  <= '0;
          end
        end
        S_CLEAR: begin
          r_state <= S_BURST;
          trigger <= 1'b0;
        end
        S_BURST: begin
          if (sample_en) begin
            if (r_count == r_len) begin
              r_state <= S_RING;
              dnoise  <= '0;
              trigger <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              dnoise  <= w_noise;
              r_lfsr  <= w_lfsr_next;
              r_count <= r_count + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ks_excite_gen.sv
// ---------------------------------------------------------------------------
// tb_ks_excite_gen : scoreboard bench for ks_excite_gen, directed vectors
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ks_excite_gen;

  logic        a_clk = 1'b0;
  logic        reset_n;
  logic        sample_en;
  logic        pluck;
  logic [11:0] burst_len;
  logic [3:0]  amp_shift;
  logic [15:0] dnoise;
  logic        trigger;
  logic        sclr;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [15:0] dn;
    logic        tr;
    logic        sc;
    logic        bz;
    logic        dd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   idx    = 0;

  always #5 a_clk = ~a_clk;

  ks_excite_gen #(.WIDTH(16), .LEN_W(12), .LFSR_SEED(16'hACE1)) dut (
    .a_clk     (a_clk),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .pluck     (pluck),
    .burst_len (burst_len),
    .amp_shift (amp_shift),
    .dnoise    (dnoise),
    .trigger   (trigger),
    .sclr      (sclr),
    .busy      (busy),
    .done      (done)
  );

  // Each entry describes the outputs expected one edge after the inputs were applied.
  task automatic step(input logic rn, input logic p, input logic se,
                      input logic [15:0] d, input logic t, input logic s,
                      input logic b, input logic dd);
    reset_n   = rn;
    pluck     = p;
    sample_en = se;
    q.push_back('{dn: d, tr: t, sc: s, bz: b, dd: dd});
    @(posedge a_clk);
    #2;
  endtask

  task automatic quiet(input int n, input logic se);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, se, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares a popped expectation against the outputs just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge a_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (dnoise !== e.dn || trigger !== e.tr || sclr !== e.sc || busy !== e.bz || done !== e.dd) begin
          errors++;
          $display("FAIL out%0d got dnoise=%h trig=%b sclr=%b busy=%b done=%b exp dnoise=%h trig=%b sclr=%b busy=%b done=%b",
                   idx, dnoise, trigger, sclr, busy, done, e.dn, e.tr, e.sc, e.bz, e.dd);
        end
        idx++;
      end
    end
  end

  initial begin
    logic [15:0] seq [0:2];
    logic [15:0] cur;
    seq[0] = 16'hACE1; seq[1] = 16'hE270; seq[2] = 16'h7138;
    reset_n = 1'b0; pluck = 1'b0; sample_en = 1'b0;
    burst_len = 12'd4; amp_shift = 4'd0;
    @(posedge a_clk);
    #2;

    // 1: reset state, then idle hold
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) quiet(1, i[0]);

    // 2: 4-sample burst, pluck coincident with sample_en
    burst_len = 12'd4; amp_shift = 4'd0;
    step(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'hACE1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'hE270, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h7138, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h389C, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    quiet(2, 1'b1);
    // Re-pluck from RING: LFSR continues rather than reseeding
    burst_len = 12'd2;
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h1C4E, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0E27, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    quiet(1, 1'b1);

    // 3: amp_shift=4 from reset
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    burst_len = 12'd1; amp_shift = 4'd4;
    step(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'hFACE, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

    // 4: burst_len=0 behaves as one sample
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    burst_len = 12'd0; amp_shift = 4'd0;
    step(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'hACE1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    quiet(1, 1'b1);

    // 5: sparse strobes, hold between them, pluck mid-burst ignored
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    burst_len = 12'd3;
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    cur = 16'h0000;
    for (int s = 0; s < 4; s++) begin
      for (int h = 0; h < 7; h++)
        step(1'b1, (s == 1 && h == 0), 1'b0, cur, 1'b0, 1'b0, 1'b1, 1'b0);
      if (s < 3) begin
        cur = seq[s];
        step(1'b1, (s == 2), 1'b1, cur, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
      end
    end
    quiet(2, 1'b0);

    // 6: reset mid-burst aborts without done; restart reuses seed
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    burst_len = 12'd4;
    step(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'hACE1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'hE270, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet(3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'hACE1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Every pushed expectation must have been consumed by the monitor.
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
